// File: rtl/frac_n_divider_if.sv
// -----------------------------------------------------------------------------
// frac_n_divider_if
// Signal bundle between the delta-sigma modulator side (master) and the
// multi-modulus feedback divider (slave).
//   en         : divider enable, level sensitive
//   n_int      : unsigned integer divide word
//   dn         : signed 5-bit modulator output (-16..+15)
//   div_pulse  : one-clock strobe on the last clock of each period
//   div_clk    : divided clock, high for the first ceil(D/2) clocks
//   period     : divisor D used for the current period
//   clamp      : current period's divisor was clamped to the minimum
// -----------------------------------------------------------------------------
interface frac_n_divider_if #(
  parameter int NBITS = 8
);
  logic             en;
  logic [NBITS-1:0] n_int;
  logic [4:0]       dn;
  logic             div_pulse;
  logic             div_clk;
  logic [NBITS:0]   period;
  logic             clamp;

  modport master (
    output en, n_int, dn,
    input  div_pulse, div_clk, period, clamp
  );

  modport slave (
    input  en, n_int, dn,
    output div_pulse, div_clk, period, clamp
  );
endinterface

// File: rtl/frac_n_divider.sv
// -----------------------------------------------------------------------------
// frac_n_divider
// Multi-modulus feedback divider for a fractional-N PLL. Each output period
// lasts D = n_int + dn clocks (clamped below at MIN_DIV). The divisor is
// sampled only on the LOAD cycle and on the last clock of each period, so the
// modulator can change dn at any time without disturbing a period in flight.
//   clk   : VCO-rate clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : frac_n_divider_if.slave (en, n_int, dn in; div_pulse, div_clk,
//           period, clamp out -- all outputs registered)
// Parameters: NBITS width of n_int; MIN_DIV smallest divisor (must be >= 2).
// -----------------------------------------------------------------------------
module frac_n_divider #(
  parameter int NBITS   = 8,
  parameter int MIN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  frac_n_divider_if.slave   bus
);

  localparam int DW = NBITS + 1;  // divisor / counter width
  localparam int SW = NBITS + 2;  // signed sum width

  localparam logic signed [SW-1:0] MIN_S = SW'(MIN_DIV);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] period_q, period_d;
  logic          clamp_q, clamp_d;
  logic          pulse_q, pulse_d;
  logic          dclk_q, dclk_d;

  logic signed [SW-1:0] dsum;
  logic [DW-1:0]        div_val;
  logic                 div_clamp;

  // Divisor candidate from the inputs present this cycle; only used when the
  // FSM is at a sample point.
  always_comb begin
    dsum      = $signed({2'b00, bus.n_int}) + $signed({{(SW-5){bus.dn[4]}}, bus.dn});
    div_clamp = (dsum < MIN_S);
    div_val   = div_clamp ? DW'(MIN_DIV) : dsum[DW-1:0];
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned -- otherwise synthesis would infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    clamp_d  = clamp_q;

    unique case (state_q)
      IDLE: begin
        if (bus.en) state_d = LOAD;
      end
      LOAD: begin
        cnt_d    = div_val - DW'(1);
        period_d = div_val;
        clamp_d  = div_clamp;
        state_d  = COUNT;
      end
      COUNT: begin
        if (cnt_q == '0) begin
          // Last clock of the period: reload immediately so periods abut.
          cnt_d    = div_val - DW'(1);
          period_d = div_val;
          clamp_d  = div_clamp;
        end else begin
          cnt_d = cnt_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides everything, including a reload on the last clock.
    if (!bus.en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      clamp_d  = 1'b0;
    end

    // Outputs are decoded from the next state so that the registered copies
    // line up with the counter value they describe.
    pulse_d = (state_d == COUNT) && (cnt_d == '0);
    dclk_d  = (state_d == COUNT) && (cnt_d >= (period_d >> 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      clamp_q  <= 1'b0;
      pulse_q  <= 1'b0;
      dclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      clamp_q  <= clamp_d;
      pulse_q  <= pulse_d;
      dclk_q   <= dclk_d;
    end
  end

  assign bus.div_pulse = pulse_q;
  assign bus.div_clk   = dclk_q;
  assign bus.period    = period_q;
  assign bus.clamp     = clamp_q;

endmodule

// File: tb/tb_frac_n_divider.sv
// -----------------------------------------------------------------------------
// tb_frac_n_divider
// Directed bench for frac_n_divider. The stimulus process pushes the expected
// description of each period (pulse spacing, div_clk high count, period,
// clamp) into a queue when it presents the divisor inputs; a monitor process
// pops and compares on every div_pulse.
// -----------------------------------------------------------------------------
module tb_frac_n_divider;

  localparam int NBITS   = 8;
  localparam int MIN_DIV = 4;

  typedef struct {
    int gap;     // clocks since previous pulse (or since en sampled high)
    int hi;      // div_clk high clocks within the period
    int period;
    int clamp;
  } exp_t;

  typedef int ivec_t [8];

  logic clk;
  logic rst_n;

  frac_n_divider_if #(.NBITS(NBITS)) bus ();

  frac_n_divider #(
    .NBITS   (NBITS),
    .MIN_DIV (MIN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t exp_q[$];

  // Vector tables for run_seq: n_int, dn, hand-computed D and clamp per period.
  ivec_t t_n, t_dn, t_d, t_cl;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  function automatic logic [31:0] outs();
    return {20'd0, bus.div_pulse, bus.div_clk, bus.period, bus.clamp};
  endfunction

  function automatic void push_exp(input int d, input int cl, input bit first);
    exp_t e;
    e.gap    = first ? d + 1 : d;
    e.hi     = (d + 1) / 2;
    e.period = d;
    e.clamp  = cl;
    exp_q.push_back(e);
  endfunction

  // Advance negedge by negedge until div_pulse is seen, bounded.
  task automatic wait_pulse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.div_pulse) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("pulse_timeout", 32'd0, 32'd1);
  endtask

  // Starts at a negedge: presents period 0 inputs and enables; on each pulse
  // presents the next period's inputs (optionally scribbling dn one clock
  // later, which must be ignored). en drops on the final pulse.
  task automatic run_seq(input int cnt, input bit junk);
    bit ok;
    bus.n_int = NBITS'(t_n[0]);
    bus.dn    = 5'(t_dn[0]);
    push_exp(t_d[0], t_cl[0], 1'b1);
    bus.en = 1'b1;
    for (int k = 1; k < cnt; k++) begin
      wait_pulse(ok);
      if (!ok) return;
      bus.n_int = NBITS'(t_n[k]);
      bus.dn    = 5'(t_dn[k]);
      push_exp(t_d[k], t_cl[k], 1'b0);
      if (junk) begin
        @(negedge clk);
        bus.dn = 5'b10000;
      end
    end
    wait_pulse(ok);
    bus.en = 1'b0;
    @(negedge clk);
    check("idle_after_seq", outs(), 32'd0);
    check("scoreboard_drained", exp_q.size(), 32'd0);
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin
    int   gap;
    int   hi;
    exp_t e;
    gap = 0;
    hi  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !bus.en) begin
        if (bus.div_pulse) check("pulse_while_off", 32'd1, 32'd0);
        gap = 0;
        hi  = 0;
      end else begin
        gap++;
        if (bus.div_clk) hi++;
        if (bus.div_pulse) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("pulse_gap",   gap,        e.gap);
            check("div_clk_hi",  hi,         e.hi);
            check("period",      bus.period, e.period);
            check("clamp",       bus.clamp,  e.clamp);
          end
          gap = 0;
          hi  = 0;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.en    = 1'b0;
    bus.n_int = '0;
    bus.dn    = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_en_low", outs(), 32'd0);

    // Integer divide by 10.
    t_n  = '{10, 10, 10, 10, 0, 0, 0, 0};
    t_dn = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_d  = '{10, 10, 10, 10, 0, 0, 0, 0};
    t_cl = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_seq(4, 1'b0);

    // Alternating +1/-1 with mid-period dn scribbles (ignored).
    t_n  = '{10, 10, 10, 10, 0, 0, 0, 0};
    t_dn = '{1, -1, 1, -1, 0, 0, 0, 0};
    t_d  = '{11, 9, 11, 9, 0, 0, 0, 0};
    t_cl = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_seq(4, 1'b1);

    // Clamp boundaries, then the largest divisor.
    t_n  = '{2, 2, 0, 20, 5, 255, 255, 0};
    t_dn = '{-7, -7, -16, -16, -2, 15, -16, 0};
    t_d  = '{4, 4, 4, 4, 4, 270, 239, 0};
    t_cl = '{1, 1, 1, 0, 1, 0, 0, 0};
    run_seq(7, 1'b0);

    // Disable at cnt = 3 of a D = 12 period: no pulse, outputs clear.
    bus.n_int = 8'd12;
    bus.dn    = 5'd0;
    bus.en    = 1'b1;
    repeat (10) @(negedge clk);
    check("period_mid_abort", bus.period, 32'd12);
    check("div_clk_low_cnt3", bus.div_clk, 32'd0);
    bus.en = 1'b0;
    @(negedge clk);
    check("idle_after_abort", outs(), 32'd0);
    repeat (15) @(negedge clk);
    t_n  = '{12, 12, 0, 0, 0, 0, 0, 0};
    t_dn = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_d  = '{12, 12, 0, 0, 0, 0, 0, 0};
    t_cl = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_seq(2, 1'b0);

    // Asynchronous reset between edges mid-period.
    bus.n_int = 8'd8;
    bus.dn    = 5'd0;
    push_exp(8, 0, 1'b1);
    bus.en = 1'b1;
    repeat (5) @(negedge clk);
    check("div_clk_high_mid", bus.div_clk, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 32'd0);
    exp_q.delete();
    @(negedge clk);
    check("held_reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    t_n  = '{8, 8, 0, 0, 0, 0, 0, 0};
    t_dn = '{0, 0, 0, 0, 0, 0, 0, 0};
    t_d  = '{8, 8, 0, 0, 0, 0, 0, 0};
    t_cl = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_seq(2, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
